// File: rtl/obstacle_motion_ctrl.sv
// Obstacle sprite sequencer: RAM loader, per-frame motion, lane respawn, animation id.
// Optional OBSTACLE_CTRL_SPEEDUP_EN adds pass-count based speed-up.
module obstacle_motion_ctrl #(
    parameter int         ADDR       = 10,
    parameter int         V_DISP     = 480,
    parameter int         X_START    = 640,
    parameter int         LANE_BASE  = 352,
    parameter int         LANE_PITCH = 32,
    parameter int         ANI_DIV    = 8,
    parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [10:0]     x,
    input  logic [10:0]     y,
    input  logic            start,
    input  logic            pause,
    input  logic [3:0]      speed,
    input  logic [1:0]      color_sel,
    input  logic            load_req,
    input  logic            ld_valid,
    input  logic [1:0]      ld_data,
    output logic            ld_ready,
    output logic [10:0]     x0,
    output logic [10:0]     y0,
    output logic [4:0]      ctrl,
    output logic            we,
    output logic [ADDR-1:0] addr_w,
    output logic [1:0]      sprite_pix,
    output logic            busy,
    output logic [7:0]      pass_cnt
);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, PAUSE} state_t;

    state_t          state, state_n;
    logic            match, match_q, ftick;
    logic [ADDR-1:0] beat_cnt;
    logic [7:0]      lfsr;
    logic [7:0]      div;
    logic [1:0]      sid;
    logic [3:0]      eff_speed;
    logic            fire, step, wrap;

    assign match = (x == 11'd0) && (y == 11'(V_DISP));
    assign fire  = ld_valid && ld_ready;
    assign step  = (state == RUN) && ftick;
    assign wrap  = {7'd0, eff_speed} > x0;

`ifdef OBSTACLE_CTRL_SPEEDUP_EN
    logic [4:0] spd_sum;
    assign spd_sum   = {1'b0, speed} + {1'b0, pass_cnt[7:4]};
    assign eff_speed = spd_sum[4] ? 4'hF : spd_sum[3:0];
`else
    assign eff_speed = speed;
`endif

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (load_req)
                    state_n = LOAD;
                else if (start)
                    state_n = RUN;
            end
            LOAD: begin
                if (fire && (&beat_cnt))
                    state_n = IDLE;
            end
            RUN: begin
                if (pause)
                    state_n = PAUSE;
            end
            PAUSE: begin
                if (!pause)
                    state_n = RUN;
            end
        endcase
    end

    // ftick is a registered rising-edge detect of the frame match
    always_ff @(posedge clk) begin
        if (reset) begin
            match_q <= 1'b0;
            ftick   <= 1'b0;
        end else begin
            match_q <= match;
            ftick   <= match && !match_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            ld_ready <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_n;
            ld_ready <= (state_n == LOAD);
            busy     <= (state_n != IDLE);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            we         <= 1'b0;
            addr_w     <= '0;
            sprite_pix <= 2'd0;
            beat_cnt   <= '0;
        end else begin
            we <= fire;
            if (state == IDLE)
                beat_cnt <= '0;
            if (fire) begin
                addr_w     <= beat_cnt;
                sprite_pix <= ld_data;
                beat_cnt   <= beat_cnt + 1'b1;
            end
        end
    end

    // Lane uses the LFSR value from before this tick's advance
    always_ff @(posedge clk) begin
        if (reset) begin
            x0       <= 11'(X_START);
            y0       <= 11'(LANE_BASE);
            pass_cnt <= 8'd0;
            lfsr     <= LFSR_SEED;
            div      <= 8'd0;
            sid      <= 2'd0;
        end else if (step) begin
            if (wrap) begin
                x0 <= 11'(X_START);
                y0 <= 11'(LANE_BASE + LANE_PITCH * int'(lfsr[1:0]));
                if (pass_cnt != 8'hFF)
                    pass_cnt <= pass_cnt + 8'd1;
            end else begin
                x0 <= x0 - {7'd0, eff_speed};
            end
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            if (div == 8'(ANI_DIV - 1)) begin
                div <= 8'd0;
                sid <= sid + 2'd1;
            end else begin
                div <= div + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            ctrl <= 5'd0;
        else
            ctrl <= {color_sel, 1'b0, sid};
    end

endmodule

// File: tb/tb_obstacle_motion_ctrl.sv
// Scoreboard bench for obstacle_motion_ctrl: load writes, motion, lanes, pause,
// animation id and speed-up (OBSTACLE_CTRL_SPEEDUP_EN aware).
module tb_obstacle_motion_ctrl;

    localparam int V_DISP = 480;

`ifdef OBSTACLE_CTRL_SPEEDUP_EN
    localparam int FAST_STEP = 15;
`else
    localparam int FAST_STEP = 14;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [10:0] x = 11'd1;
    logic [10:0] y = 11'd0;
    logic        start = 1'b0;
    logic        pause = 1'b0;
    logic [3:0]  speed = 4'd0;
    logic [1:0]  color_sel = 2'd0;
    logic        load_req = 1'b0;
    logic        ld_valid = 1'b0;
    logic [1:0]  ld_data = 2'd0;
    logic        ld_ready;
    logic [10:0] x0, y0;
    logic [4:0]  ctrl;
    logic        we;
    logic [9:0]  addr_w;
    logic [1:0]  sprite_pix;
    logic        busy;
    logic [7:0]  pass_cnt;

    obstacle_motion_ctrl #(
        .ADDR(10), .V_DISP(V_DISP), .X_START(640), .LANE_BASE(352),
        .LANE_PITCH(32), .ANI_DIV(8), .LFSR_SEED(8'hA5)
    ) dut (
        .clk(clk), .reset(reset), .x(x), .y(y), .start(start),
        .pause(pause), .speed(speed), .color_sel(color_sel),
        .load_req(load_req), .ld_valid(ld_valid), .ld_data(ld_data),
        .ld_ready(ld_ready), .x0(x0), .y0(y0), .ctrl(ctrl), .we(we),
        .addr_w(addr_w), .sprite_pix(sprite_pix), .busy(busy),
        .pass_cnt(pass_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [10:0] x0;
        logic [10:0] y0;
        logic [7:0]  pass;
        logic [4:0]  ctrl;
        logic        busy;
        logic        ld_ready;
        logic        chk_addr;
        logic [9:0]  addr;
    } st_t;

    typedef struct {
        logic [9:0] addr;
        logic [1:0] data;
    } wr_t;

    st_t  st_q[$];
    wr_t  wr_q[$];
    int   checks = 0;
    int   errors = 0;
    int   we_cnt = 0;
    logic chk_req = 1'b0;

    // reference model: 0 idle, 1 run, 2 pause, 3 load
    int          m_state;
    logic [10:0] m_x, m_y;
    logic [7:0]  m_pass, m_lfsr, m_div;
    logic [1:0]  m_sid;

    // write monitor
    always @(negedge clk) begin
        wr_t w;
        if (we) begin
            we_cnt++;
            checks++;
            if (wr_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_we: got addr=%0d data=%0d, want no write",
                         addr_w, sprite_pix);
            end else begin
                w = wr_q.pop_front();
                if (addr_w !== w.addr || sprite_pix !== w.data) begin
                    errors++;
                    $display("FAIL write: got addr=%0d data=%0d, want addr=%0d data=%0d",
                             addr_w, sprite_pix, w.addr, w.data);
                end
            end
        end
    end

    // status monitor
    always @(negedge clk) begin
        st_t s;
        if (chk_req) begin
            checks++;
            if (st_q.size() == 0) begin
                errors++;
                $display("FAIL status_queue: empty at check request");
            end else begin
                s = st_q.pop_front();
                if (x0 !== s.x0 || y0 !== s.y0 || pass_cnt !== s.pass ||
                    ctrl !== s.ctrl || busy !== s.busy ||
                    ld_ready !== s.ld_ready ||
                    (s.chk_addr && addr_w !== s.addr) || (s.chk_addr && we !== 1'b0)) begin
                    errors++;
                    $display("FAIL status: got x0=%0d y0=%0d pass=%0d ctrl=%b busy=%b rdy=%b addr=%0d we=%b, want x0=%0d y0=%0d pass=%0d ctrl=%b busy=%b rdy=%b addr=%0d(chk=%b)",
                             x0, y0, pass_cnt, ctrl, busy, ld_ready, addr_w, we,
                             s.x0, s.y0, s.pass, s.ctrl, s.busy, s.ld_ready,
                             s.addr, s.chk_addr);
                end
            end
        end
    end

    task automatic check(input bit ok, input string name, input int got, input int want);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_x     = 11'd640;
        m_y     = 11'd352;
        m_pass  = 8'd0;
        m_lfsr  = 8'hA5;
        m_div   = 8'd0;
        m_sid   = 2'd0;
    endtask

    task automatic model_tick();
        int eff;
        if (m_state != 1)
            return;
        eff = int'(speed);
`ifdef OBSTACLE_CTRL_SPEEDUP_EN
        eff = eff + int'(m_pass[7:4]);
        if (eff > 15)
            eff = 15;
`endif
        if (int'(m_x) < eff) begin
            m_x = 11'd640;
            m_y = 11'(352 + 32 * int'(m_lfsr[1:0]));
            if (m_pass != 8'hFF)
                m_pass = m_pass + 8'd1;
        end else begin
            m_x = m_x - 11'(eff);
        end
        m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
        if (m_div == 8'd7) begin
            m_div = 8'd0;
            m_sid = m_sid + 2'd1;
        end else begin
            m_div = m_div + 8'd1;
        end
    endtask

    // push expectation (model, with optional hand overrides) and request a check
    task automatic push_st(input int hx, input int hp, input int hs,
                           input bit ca, input int ha);
        st_t s;
        s.x0       = (hx >= 0) ? 11'(hx) : m_x;
        s.y0       = m_y;
        s.pass     = (hp >= 0) ? 8'(hp) : m_pass;
        s.ctrl     = {color_sel, 1'b0, (hs >= 0) ? 2'(hs) : m_sid};
        s.busy     = (m_state != 0);
        s.ld_ready = (m_state == 3);
        s.chk_addr = ca;
        s.addr     = 10'(ha);
        st_q.push_back(s);
        chk_req = 1'b1;
        @(posedge clk);
        #1 chk_req = 1'b0;
    endtask

    task automatic do_frame(input int hx, input int hp, input int hs, input bit pz);
        x = 11'd0;
        y = 11'(V_DISP);
        @(posedge clk);
        #1 x = 11'd1;
        y = 11'd0;
        if (pz)
            pause = 1'b1;
        @(posedge clk);
        #1 model_tick();
        if (pz)
            m_state = 2;
        @(posedge clk);
        #1 push_st(hx, hp, hs, 1'b0, 0);
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        x        = 11'd1;
        y        = 11'd0;
        start    = 1'b0;
        load_req = 1'b0;
        ld_valid = 1'b0;
        pause    = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        m_state = 1;
    endtask

    task automatic set_pause(input logic v);
        pause = v;
        @(posedge clk);
        #1 m_state = v ? 2 : 1;
        @(posedge clk);
        #1;
    endtask

    task automatic load_beat(input int i);
        ld_valid = 1'b1;
        ld_data  = 2'(i % 4);
        if (!ld_ready) begin
            check(1'b0, "ld_ready_during_load", 0, 1);
        end else begin
            wr_q.push_back('{addr: 10'(i), data: 2'(i % 4)});
        end
        @(posedge clk);
        #1 ld_valid = 1'b0;
    endtask

    initial begin
        int hx, hp, hs, prev_pass, n;
        model_reset();
        @(posedge clk);
        #1 do_reset();
        push_st(-1, -1, -1, 1'b1, 0);

        // full RAM load, valid toggling
        load_req = 1'b1;
        @(posedge clk);
        #1 load_req = 1'b0;
        m_state = 3;
        push_st(-1, -1, -1, 1'b0, 0);
        for (int i = 0; i < 1024; i++) begin
            @(posedge clk);
            #1 load_beat(i);
        end
        m_state = 0;
        @(posedge clk);
        #1 push_st(-1, -1, -1, 1'b0, 0);
        check(we_cnt == 1024, "we_pulse_count", we_cnt, 1024);
        check(wr_q.size() == 0, "writes_pending", wr_q.size(), 0);

        // reset in the middle of a load
        load_req = 1'b1;
        @(posedge clk);
        #1 load_req = 1'b0;
        m_state = 3;
        for (int i = 0; i < 5; i++)
            load_beat(i);
        @(posedge clk);
        #1 do_reset();
        push_st(-1, -1, -1, 1'b1, 0);
        check(we_cnt == 1029, "midload_we_count", we_cnt, 1029);

        // motion, speed 4
        speed = 4'd4;
        do_start();
        push_st(-1, -1, -1, 1'b0, 0);
        for (int f = 1; f <= 161; f++) begin
            hx = (f == 1) ? 636 : (f == 159) ? 4 : (f == 160) ? 0 :
                 (f == 161) ? 640 : -1;
            hp = (f == 161) ? 1 : -1;
            do_frame(hx, hp, -1, 1'b0);
        end

        // pause
        set_pause(1'b1);
        for (int f = 0; f < 5; f++)
            do_frame(640, 1, -1, 1'b0);
        set_pause(1'b0);
        do_frame(636, 1, -1, 1'b0);
        do_frame(632, 1, -1, 1'b0);
        do_frame(628, 1, -1, 1'b1);
        do_frame(628, 1, -1, 1'b0);
        set_pause(1'b0);
        do_frame(624, 1, -1, 1'b0);

        // lane selection over 20 wraps
        do_reset();
        speed = 4'd15;
        do_start();
        n = 0;
        while (m_pass < 8'd20 && n < 2000) begin
            do_frame(-1, -1, -1, 1'b0);
            n++;
        end
        check(n < 2000, "lane_frame_budget", n, 2000);

        // animation id, stationary sprite
        do_reset();
        speed = 4'd0;
        color_sel = 2'b10;
        do_start();
        for (int f = 1; f <= 32; f++) begin
            if (f == 20)
                color_sel = 2'b01;
            hs = (f == 8) ? 1 : (f == 16) ? 2 : (f == 24) ? 3 :
                 (f == 32) ? 0 : -1;
            do_frame(640, 0, hs, 1'b0);
        end
        color_sel = 2'b00;

        // speed-up after 16 and 32 passes
        do_reset();
        speed = 4'd14;
        do_start();
        n = 0;
        while (m_pass < 8'd33 && n < 3000) begin
            prev_pass = int'(m_pass);
            do_frame(-1, -1, -1, 1'b0);
            n++;
            if (int'(m_pass) != prev_pass && (m_pass == 8'd16 || m_pass == 8'd32)) begin
                do_frame(640 - FAST_STEP, -1, -1, 1'b0);
                n++;
            end
        end
        check(n < 3000, "speedup_frame_budget", n, 3000);

        repeat (3) @(posedge clk);
        check(st_q.size() == 0, "status_pending", st_q.size(), 0);
        check(wr_q.size() == 0, "writes_left", wr_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
